// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the RV32 MEM stage (memory_cycle).
// `DMEM_PERF_CNT_EN adds the load/store access counters to the stage.
package memory_cycle_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DmemDepth = 1024;
  localparam int unsigned RegIdxW   = 5;

  typedef struct packed {
    logic               reg_write;
    logic               result_src;
    logic [RegIdxW-1:0] rd;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    read_data;
    logic               misalign;
  } mem_wb_t;

  // Only memory ops (load or store) can be misaligned.
  function automatic logic is_misaligned(logic [1:0] byte_off, logic mem_write, logic load);
    return (byte_off != 2'b00) & (mem_write | load);
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage; master = upstream/testbench side.
// Counter signals exist only when `DMEM_PERF_CNT_EN is defined.
interface memory_cycle_if;
  import memory_cycle_pkg::*;

  logic               RegWriteM;
  logic               MemWriteM;
  logic               ResultSrcM;
  logic [RegIdxW-1:0] RD_M;
  logic [XLEN-1:0]    PCPlus4M;
  logic [XLEN-1:0]    WriteDataM;
  logic [XLEN-1:0]    ALU_ResultM;

  logic               RegWriteW;
  logic               ResultSrcW;
  logic [RegIdxW-1:0] RD_W;
  logic [XLEN-1:0]    PCPlus4W;
  logic [XLEN-1:0]    ALU_ResultW;
  logic [XLEN-1:0]    ReadDataW;
  logic               MisalignW;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]        LoadCntW;
  logic [31:0]        StoreCntW;
`endif

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
`ifdef DMEM_PERF_CNT_EN
    input  LoadCntW, StoreCntW,
`endif
    input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
`ifdef DMEM_PERF_CNT_EN
    output LoadCntW, StoreCntW,
`endif
    output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
  );

endinterface

// File: rtl/memory_cycle_data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write, zero at time 0.
module memory_cycle_data_mem
  import memory_cycle_pkg::*;
#(
  parameter int unsigned Depth = DmemDepth,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the RV32 pipeline: word load/store, misalign detection, MEM/WB register.
// `DMEM_PERF_CNT_EN enables the LoadCntW/StoreCntW access counters.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = DmemDepth
) (
  input logic           clk,
  input logic           rst,
  memory_cycle_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DMEM_DEPTH);

  logic [ADDR_W-1:0] idx;
  logic [XLEN-1:0]   rdata;
  logic              misalign;
  logic              bad_load;
  logic              store_ok;
  mem_wb_t           wb_d, wb_q;

  // Upper address bits are ignored, so addresses alias modulo the memory size.
  assign idx      = bus.ALU_ResultM[ADDR_W+1:2];
  assign misalign = is_misaligned(bus.ALU_ResultM[1:0], bus.MemWriteM, bus.ResultSrcM);
  assign bad_load = misalign & bus.ResultSrcM;
  assign store_ok = bus.MemWriteM & ~misalign & ~rst;

  memory_cycle_data_mem #(
    .Depth (DMEM_DEPTH),
    .AddrW (ADDR_W)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (store_ok),
    .addr_i  (idx),
    .wdata_i (bus.WriteDataM),
    .rdata_o (rdata)
  );

  always_comb begin
    wb_d            = '0;
    wb_d.reg_write  = bus.RegWriteM & ~bad_load;
    wb_d.result_src = bus.ResultSrcM;
    wb_d.rd         = bus.RD_M;
    wb_d.pc_plus4   = bus.PCPlus4M;
    wb_d.alu_result = bus.ALU_ResultM;
    wb_d.read_data  = bad_load ? '0 : rdata;
    wb_d.misalign   = misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign bus.RegWriteW   = wb_q.reg_write;
  assign bus.ResultSrcW  = wb_q.result_src;
  assign bus.RD_W        = wb_q.rd;
  assign bus.PCPlus4W    = wb_q.pc_plus4;
  assign bus.ALU_ResultW = wb_q.alu_result;
  assign bus.ReadDataW   = wb_q.read_data;
  assign bus.MisalignW   = wb_q.misalign;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] load_cnt_q, store_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (bus.ResultSrcM & ~misalign) load_cnt_q  <= load_cnt_q + 32'd1;
      if (bus.MemWriteM & ~misalign)  store_cnt_q <= store_cnt_q + 32'd1;
    end
  end

  assign bus.LoadCntW  = load_cnt_q;
  assign bus.StoreCntW = store_cnt_q;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: directed cases followed by random load/store/ALU traffic.
module tb_memory_cycle;
  import memory_cycle_pkg::*;

  localparam int unsigned Depth = DmemDepth;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_cycle_if bus ();

  memory_cycle #(.DMEM_DEPTH(Depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit        rw;
    bit        rs;
    bit [4:0]  rd;
    bit [31:0] pc;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit        chk_rdata;
    bit        mis;
    bit [31:0] lc;
    bit [31:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  bit   [31:0] ref_mem [Depth];
  bit   [31:0] ref_lc, ref_sc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte address -> word index modulo Depth; one result per cycle.
  task automatic issue(input bit r, input bit rw, input bit mw, input bit rs,
                       input bit [4:0] rd, input bit [31:0] pc, input bit [31:0] wd,
                       input bit [31:0] alu);
    exp_t        e;
    int unsigned word;
    bit          mis;
    @(negedge clk);
    rst             = r;
    bus.RegWriteM   = rw;
    bus.MemWriteM   = mw;
    bus.ResultSrcM  = rs;
    bus.RD_M        = rd;
    bus.PCPlus4M    = pc;
    bus.WriteDataM  = wd;
    bus.ALU_ResultM = alu;
    e = '{default: 0};
    e.chk_rdata = 1'b1;
    if (r) begin
      ref_lc = 0;
      ref_sc = 0;
    end else begin
      word = (alu / 4) % Depth;
      mis  = (alu % 4 != 0) && (mw || rs);
      e.rw  = rw && !(mis && rs);
      e.rs  = rs;
      e.rd  = rd;
      e.pc  = pc;
      e.alu = alu;
      e.mis = mis;
      e.rdata     = (mis && rs) ? 32'h0 : ref_mem[word];
      e.chk_rdata = !mw;
      if (rs && !mis) ref_lc = ref_lc + 1;
      if (mw && !mis) begin
        ref_sc = ref_sc + 1;
        ref_mem[word] = wd;
      end
      e.lc = ref_lc;
      e.sc = ref_sc;
    end
    exp_q.push_back(e);
  endtask

  task automatic load(input bit [4:0] rd, input bit [31:0] a);
    issue(0, 1, 0, 1, rd, $urandom(), $urandom(), a);
  endtask

  task automatic store(input bit [31:0] d, input bit [31:0] a);
    issue(0, 0, 1, 0, 5'd0, $urandom(), d, a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("RegWriteW", 32'(bus.RegWriteW), 32'(e.rw));
        check("ResultSrcW", 32'(bus.ResultSrcW), 32'(e.rs));
        check("RD_W", 32'(bus.RD_W), 32'(e.rd));
        check("PCPlus4W", bus.PCPlus4W, e.pc);
        check("ALU_ResultW", bus.ALU_ResultW, e.alu);
        check("MisalignW", 32'(bus.MisalignW), 32'(e.mis));
        if (e.chk_rdata) check("ReadDataW", bus.ReadDataW, e.rdata);
`ifdef DMEM_PERF_CNT_EN
        check("LoadCntW", bus.LoadCntW, e.lc);
        check("StoreCntW", bus.StoreCntW, e.sc);
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned op;
    bit [31:0]   a;
    bit          r;
    rst             = 1'b1;
    bus.RegWriteM   = 1'b0;
    bus.MemWriteM   = 1'b0;
    bus.ResultSrcM  = 1'b0;
    bus.RD_M        = '0;
    bus.PCPlus4M    = '0;
    bus.WriteDataM  = '0;
    bus.ALU_ResultM = '0;
    ref_lc = 0;
    ref_sc = 0;

    // Reset with a pending store: nothing may reach memory.
    issue(1, 1, 1, 0, 5'd3, 32'h4, 32'hCAFE_F00D, 32'h0);
    issue(1, 1, 1, 0, 5'd3, 32'h4, 32'hCAFE_F00D, 32'h0);
    load(5'd1, 32'h0);
    // Store then load of the same word on the next cycle.
    store(32'hDEAD_BEEF, 32'h10);
    load(5'd9, 32'h10);
    // Misaligned store is dropped; misaligned load returns zero.
    store(32'h1111_2222, 32'h12);
    load(5'd10, 32'h10);
    load(5'd11, 32'h13);
    // Aliasing of the upper address bits.
    store(32'h55, 4 * Depth);
    load(5'd12, 32'h0);
    // Plain ALU op and a bubble.
    issue(0, 1, 0, 0, 5'd7, 32'h100, 32'h0, 32'h1234);
    issue(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) * 4 * Depth) + ($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
      r  = ($urandom_range(0, 39) == 0);
      if (op <= 2)      issue(r, 1, 0, 1, 5'($urandom()), $urandom(), $urandom(), a);
      else if (op <= 5) issue(r, 0, 1, 0, 5'($urandom()), $urandom(), $urandom(), a);
      else if (op <= 7) issue(r, 1, 0, 0, 5'($urandom()), $urandom(), $urandom(), $urandom());
      else if (op == 8) issue(r, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      else              issue(r, $urandom_range(0, 1), 0, 0, 5'($urandom()), $urandom(),
                              $urandom(), a);
    end

    issue(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    issue(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
